// File: rtl/option_bundle_pkg.sv
// option_bundle_pkg: shared types and default sizes for the option-bundle stimulus source.
// Macro OPT_FIELD_B_EN: when defined, the bundle carries the optional field b.
package option_bundle_pkg;

  localparam int unsigned DEF_W           = 8;
  localparam int unsigned DEF_NUM_XFERS   = 16;
  localparam logic [7:0]  DEF_SEED        = 8'h10;
  localparam int unsigned DEF_STALL_LIMIT = 64;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DONE,
    FAIL
  } state_e;

  // Bundle at default width, for consumers that work with the default build.
  typedef struct packed {
    logic [DEF_W-1:0] a;
`ifdef OPT_FIELD_B_EN
    logic [DEF_W-1:0] b;
`endif
  } bundle_t;

endpackage

// File: rtl/stall_watchdog.sv
// stall_watchdog: counts consecutive stalled cycles and trips at LIMIT.
//   clk_i   : clock, rising edge
//   rst_i   : synchronous active-high reset
//   stall_i : one stalled cycle (valid held without ready)
//   clear_i : accept; clears the count and wins over stall_i
//   trip_o  : count has reached LIMIT
module stall_watchdog #(
  parameter int unsigned LIMIT = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic stall_i,
  input  logic clear_i,
  output logic trip_o
);

  localparam int unsigned     CW  = $clog2(LIMIT + 1);
  localparam logic [CW-1:0]   MAX = CW'(LIMIT);

  logic [CW-1:0] cnt_q, cnt_d;

  // Saturate at LIMIT so the counter cannot wrap back below the trip point.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (stall_i && (cnt_q != MAX)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign trip_o = (cnt_q == MAX);

endmodule

// File: rtl/option_bundle_stim_source.sv
// option_bundle_stim_source: emits NUM_XFERS bundle transactions on a valid/ready port,
// then raises done. A stall watchdog raises err if ready is withheld too long.
// Macro OPT_FIELD_B_EN: adds port out_b and the b register (b = ~a per transaction).
//   clock, reset : rising-edge clock, synchronous active-high reset
//   start        : pulse, starts a run from IDLE
//   out_valid/out_ready : transaction handshake
//   out_a, out_b : bundle fields
//   sent_count   : accepted transactions this run (saturates at NUM_XFERS)
//   done, err    : run complete / watchdog tripped (levels, sticky until reset)
module option_bundle_stim_source
  import option_bundle_pkg::*;
#(
  parameter int unsigned   W           = DEF_W,
  parameter int unsigned   NUM_XFERS   = DEF_NUM_XFERS,
  parameter logic [W-1:0]  SEED        = W'(DEF_SEED),
  parameter int unsigned   STALL_LIMIT = DEF_STALL_LIMIT
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           start,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [W-1:0]                   out_a,
`ifdef OPT_FIELD_B_EN
  output logic [W-1:0]                   out_b,
`endif
  output logic [$clog2(NUM_XFERS+1)-1:0] sent_count,
  output logic                           done,
  output logic                           err
);

  localparam int unsigned   CW       = $clog2(NUM_XFERS + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(NUM_XFERS);
  localparam logic [CW-1:0] CNT_LAST = CW'(NUM_XFERS - 1);

  state_e        state_q, state_d;
  logic [W-1:0]  a_q, a_d, a_inc;
  logic [CW-1:0] count_q, count_d;
  logic          accept, stall, trip;
`ifdef OPT_FIELD_B_EN
  logic [W-1:0]  b_q, b_d;
`endif

  // Valid is purely a function of state: it is high for every SEND cycle, which
  // gives hold-until-accept and drop-only-on-DONE/FAIL/reset for free.
  assign out_valid  = (state_q == SEND);
  assign done       = (state_q == DONE);
  assign err        = (state_q == FAIL);
  assign out_a      = a_q;
  assign sent_count = count_q;
`ifdef OPT_FIELD_B_EN
  assign out_b      = b_q;
`endif

  assign accept = out_valid & out_ready;
  assign stall  = out_valid & ~out_ready;
  assign a_inc  = a_q + W'(1);

  stall_watchdog #(
    .LIMIT (STALL_LIMIT)
  ) u_watchdog (
    .clk_i   (clock),
    .rst_i   (reset),
    .stall_i (stall),
    .clear_i (accept),
    .trip_o  (trip)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    count_d = count_q;
`ifdef OPT_FIELD_B_EN
    b_d     = b_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) state_d = SEND;
      end
      SEND: begin
        // An accept takes priority over a coincident watchdog trip.
        if (accept) begin
          a_d = a_inc;
`ifdef OPT_FIELD_B_EN
          b_d = ~a_inc;
`endif
          if (count_q != CNT_MAX) count_d = count_q + CW'(1);
          if (count_q == CNT_LAST) state_d = DONE;
        end else if (trip) begin
          state_d = FAIL;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= SEED;
      count_q <= '0;
`ifdef OPT_FIELD_B_EN
      b_q     <= ~SEED;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      count_q <= count_d;
`ifdef OPT_FIELD_B_EN
      b_q     <= b_d;
`endif
    end
  end

endmodule

// File: tb/tb_option_bundle_stim_source.sv
// Testbench for option_bundle_stim_source (default build and OPT_FIELD_B_EN build).
module tb_option_bundle_stim_source;
  import option_bundle_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       ready = 1'b0;
  logic       valid, done, err;
  logic [7:0] a;
  logic [4:0] cnt;
`ifdef OPT_FIELD_B_EN
  logic [7:0] b;
`endif

  logic       start4 = 1'b0;
  logic       ready4 = 1'b0;
  logic       valid4, done4, err4;
  logic [7:0] a4;
  logic [2:0] cnt4;
`ifdef OPT_FIELD_B_EN
  logic [7:0] b4;
`endif

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  option_bundle_stim_source u_dut (
    .clock      (clk),
    .reset      (rst),
    .start      (start),
    .out_valid  (valid),
    .out_ready  (ready),
    .out_a      (a),
`ifdef OPT_FIELD_B_EN
    .out_b      (b),
`endif
    .sent_count (cnt),
    .done       (done),
    .err        (err)
  );

  option_bundle_stim_source #(
    .SEED      (8'hFE),
    .NUM_XFERS (4)
  ) u_dut4 (
    .clock      (clk),
    .reset      (rst),
    .start      (start4),
    .out_valid  (valid4),
    .out_ready  (ready4),
    .out_a      (a4),
`ifdef OPT_FIELD_B_EN
    .out_b      (b4),
`endif
    .sent_count (cnt4),
    .done       (done4),
    .err        (err4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    start4 = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic kick();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  bundle_t t4[4];

  initial begin
    t4[0].a = 8'hFE; t4[1].a = 8'hFF; t4[2].a = 8'h00; t4[3].a = 8'h01;
`ifdef OPT_FIELD_B_EN
    t4[0].b = 8'h01; t4[1].b = 8'h00; t4[2].b = 8'hFF; t4[3].b = 8'hFE;
`endif

    // Reset state
    do_reset();
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_a", 32'(a), 32'h10);
`ifdef OPT_FIELD_B_EN
    check("rst_b", 32'(b), 32'hEF);
`endif
    check("rst_cnt", 32'(cnt), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);

    // Test 1: ready held high, back-to-back accepts
    ready = 1'b1;
    kick();
    for (int i = 0; i < 16; i++) begin
      check("t1_valid", 32'(valid), 32'd1);
      check("t1_a", 32'(a), 32'h10 + 32'(i));
`ifdef OPT_FIELD_B_EN
      check("t1_b", 32'(b), 32'(~(8'h10 + 8'(i))));
`endif
      check("t1_cnt", 32'(cnt), 32'(i));
      step();
    end
    check("t1_done", 32'(done), 32'd1);
    check("t1_valid_off", 32'(valid), 32'd0);
    check("t1_cnt_end", 32'(cnt), 32'd16);

    // Test 6: start ignored in DONE
    kick();
    step();
    check("t6_done", 32'(done), 32'd1);
    check("t6_valid", 32'(valid), 32'd0);
    check("t6_cnt", 32'(cnt), 32'd16);
    check("t6_a", 32'(a), 32'h20);

    // Test 2: ready toggles 0/1; data holds during stalls
    do_reset();
    kick();
    begin
      int unsigned idx = 0;
      for (int c = 0; c < 32; c++) begin
        ready = (c % 2) == 1;
        check("t2_valid", 32'(valid), 32'd1);
        check("t2_a", 32'(a), 32'h10 + idx);
        if (ready) idx++;
        step();
      end
    end
    check("t2_done", 32'(done), 32'd1);
    check("t2_err", 32'(err), 32'd0);
    check("t2_cnt", 32'(cnt), 32'd16);

    // Test 3: ready never given -> watchdog trips
    ready = 1'b0;
    do_reset();
    kick();
    for (int k = 0; k <= 64; k++) begin
      check("t3_valid_held", 32'(valid), 32'd1);
      check("t3_err_low", 32'(err), 32'd0);
      step();
    end
    check("t3_err", 32'(err), 32'd1);
    check("t3_valid_off", 32'(valid), 32'd0);
    check("t3_done", 32'(done), 32'd0);
    check("t3_cnt", 32'(cnt), 32'd0);

    // Accept on the same cycle the limit is reached wins over the trip
    do_reset();
    kick();
    for (int k = 0; k < 64; k++) step();
    ready = 1'b1;
    step();
    ready = 1'b0;
    check("tc_err", 32'(err), 32'd0);
    check("tc_valid", 32'(valid), 32'd1);
    check("tc_a", 32'(a), 32'h11);
    check("tc_cnt", 32'(cnt), 32'd1);
    for (int k = 0; k < 64; k++) step();
    check("tc_no_early_trip", 32'(err), 32'd0);

    // Test 5: reset after 5 accepts aborts, then replays from SEED
    do_reset();
    ready = 1'b1;
    kick();
    for (int k = 0; k < 5; k++) step();
    check("t5_cnt5", 32'(cnt), 32'd5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_valid", 32'(valid), 32'd0);
    check("t5_cnt", 32'(cnt), 32'd0);
    check("t5_a", 32'(a), 32'h10);
    check("t5_done", 32'(done), 32'd0);
    kick();
    check("t5_replay_a0", 32'(a), 32'h10);
    step();
    check("t5_replay_a1", 32'(a), 32'h11);
    ready = 1'b0;

    // Test 4: SEED=FE, NUM_XFERS=4, wrap through zero
    do_reset();
    ready4 = 1'b1;
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("t4_valid", 32'(valid4), 32'd1);
      check("t4_a", 32'(a4), 32'(t4[i].a));
`ifdef OPT_FIELD_B_EN
      check("t4_b", 32'(b4), 32'(t4[i].b));
`endif
      step();
    end
    check("t4_done", 32'(done4), 32'd1);
    check("t4_cnt", 32'(cnt4), 32'd4);
    check("t4_err", 32'(err4), 32'd0);
    check("t4_a_after", 32'(a4), 32'h02);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
